// File: rtl/ext_pkg.sv
// ext_pkg: shared definitions for the immediate extension unit.
`default_nettype none

package ext_pkg;

  typedef enum logic [1:0] {
    MODE_SIGN    = 2'b00,
    MODE_ZERO    = 2'b01,
    MODE_UPPER   = 2'b10,
    MODE_ILLEGAL = 2'b11
  } ext_mode_e;

  localparam int EXT_DEF_IN_W  = 17;
  localparam int EXT_DEF_OUT_W = 32;
  localparam int EXT_DEF_DEPTH = 2;

endpackage : ext_pkg

`default_nettype wire

// File: rtl/ext_fifo.sv
// ext_fifo: DEPTH-entry synchronous FIFO with async active-low reset.
`default_nettype none

module ext_fifo
  import ext_pkg::*;
#(
  parameter int WIDTH = EXT_DEF_OUT_W + 1,
  parameter int DEPTH = EXT_DEF_DEPTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

  // A full FIFO refuses a push even when a pop frees a slot this cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  assign dout_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

endmodule : ext_fifo

`default_nettype wire

// File: rtl/ext_unit.sv
// ext_unit: sign/zero/upper immediate extension into a buffered result stream.
`default_nettype none

module ext_unit
  import ext_pkg::*;
#(
  parameter int IN_W  = EXT_DEF_IN_W,
  parameter int OUT_W = EXT_DEF_OUT_W,
  parameter int DEPTH = EXT_DEF_DEPTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err,
  output logic [15:0]      ext_count
);

  localparam int EXT_W = OUT_W - IN_W;

  logic             full, empty, accept;
  logic [OUT_W-1:0] ext_data;
  logic             ext_err;
  logic [OUT_W:0]   fifo_dout;
  logic [15:0]      ext_count_q, ext_count_d;

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign accept    = in_valid & ~full;

  always_comb begin
    ext_data = {{EXT_W{in_data[IN_W-1]}}, in_data};
    ext_err  = 1'b0;
    case (in_mode)
      MODE_SIGN:    ext_data = {{EXT_W{in_data[IN_W-1]}}, in_data};
      MODE_ZERO:    ext_data = {{EXT_W{1'b0}}, in_data};
      MODE_UPPER:   ext_data = {in_data, {EXT_W{1'b0}}};
      MODE_ILLEGAL: ext_err  = 1'b1;
      default:      ext_err  = 1'b1;
    endcase
  end

  ext_fifo #(
    .WIDTH (OUT_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (in_valid),
    .pop_i   (out_ready),
    .din_i   ({ext_err, ext_data}),
    .dout_o  (fifo_dout),
    .full_o  (full),
    .empty_o (empty)
  );

  assign out_err  = fifo_dout[OUT_W];
  assign out_data = fifo_dout[OUT_W-1:0];

  assign ext_count_d = accept ? ext_count_q + 16'd1 : ext_count_q;
  assign ext_count   = ext_count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ext_count_q <= '0;
    end else begin
      ext_count_q <= ext_count_d;
    end
  end

endmodule : ext_unit

`default_nettype wire

// File: tb/tb_ext_unit.sv
// tb_ext_unit: table-driven vectors plus directed sequences for ext_unit.
`default_nettype none

module tb_ext_unit;
  import ext_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic [15:0] ext_count;

  int          tests;
  int          fails;
  logic [15:0] exp_count;

  typedef struct {
    logic [1:0]  mode;
    logic [16:0] data;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  ext_unit #(
    .IN_W  (17),
    .OUT_W (32),
    .DEPTH (2)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .ext_count (ext_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [16:0] d;
    int          n;
    tests = 0;
    fails = 0;
    exp_count = '0;

    vecs[0] = '{MODE_SIGN,    17'h10000, 32'hFFFF0000, 1'b0};
    vecs[1] = '{MODE_ZERO,    17'h10000, 32'h00010000, 1'b0};
    vecs[2] = '{MODE_UPPER,   17'h00001, 32'h00008000, 1'b0};
    vecs[3] = '{MODE_ILLEGAL, 17'h1FFFF, 32'hFFFFFFFF, 1'b1};
    vecs[4] = '{MODE_SIGN,    17'h0FFFF, 32'h0000FFFF, 1'b0};
    vecs[5] = '{MODE_ZERO,    17'h1FFFF, 32'h0001FFFF, 1'b0};
    vecs[6] = '{MODE_UPPER,   17'h1FFFF, 32'hFFFF8000, 1'b0};
    vecs[7] = '{MODE_ILLEGAL, 17'h00001, 32'h00000001, 1'b1};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = MODE_SIGN;
    out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_err",   32'(out_err),   32'd0);
    chk("rst_out_data",  out_data,       32'd0);
    chk("rst_ext_count", 32'(ext_count), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Single transactions: first one lands on the first edge after reset release.
    for (int i = 0; i < 8; i++) begin
      in_valid  = 1'b1;
      in_mode   = vecs[i].mode;
      in_data   = vecs[i].data;
      out_ready = 1'b0;
      tick();
      in_valid  = 1'b0;
      exp_count = exp_count + 16'd1;
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_data", i),  out_data,       vecs[i].exp_data);
      chk($sformatf("vec%0d_err", i),   32'(out_err),   32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_count", i), 32'(ext_count), 32'(exp_count));
      out_ready = 1'b1;
      tick();
      chk($sformatf("vec%0d_drained", i), 32'(out_valid), 32'd0);
      out_ready = 1'b0;
    end

    // Backpressure: fill, hold off a third request, then drain in order.
    in_valid = 1'b1; in_mode = MODE_SIGN; in_data = 17'h00005;
    tick(); exp_count = exp_count + 16'd1;
    chk("bp_ready_after1", 32'(in_ready), 32'd1);
    in_mode = MODE_ZERO; in_data = 17'h10001;
    tick(); exp_count = exp_count + 16'd1;
    chk("bp_ready_after2", 32'(in_ready), 32'd0);
    in_mode = MODE_UPPER; in_data = 17'h00003;
    tick();
    chk("bp_held_count", 32'(ext_count), 32'(exp_count));
    chk("bp_held_head",  out_data,       32'h00000005);
    out_ready = 1'b1;
    tick();
    chk("bp_pop_full_count", 32'(ext_count), 32'(exp_count));
    chk("bp_second_head",    out_data,       32'h00010001);
    chk("bp_ready_again",    32'(in_ready),  32'd1);
    tick(); exp_count = exp_count + 16'd1;
    chk("bp_third_head",  out_data,       32'h00018000);
    chk("bp_third_count", 32'(ext_count), 32'(exp_count));
    in_valid = 1'b0;
    tick();
    chk("bp_drained", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Steady push+pop at occupancy 1.
    in_valid = 1'b1; in_mode = MODE_ZERO; in_data = 17'h00100;
    tick(); exp_count = exp_count + 16'd1;
    for (int i = 1; i <= 10; i++) begin
      d = 17'h00100 + 17'(i * 17'h00111);
      chk($sformatf("ss%0d_head", i), out_data, {15'd0, 17'h00100 + 17'((i - 1) * 17'h00111)});
      in_data   = d;
      out_ready = 1'b1;
      tick(); exp_count = exp_count + 16'd1;
      chk($sformatf("ss%0d_occ1", i), {30'd0, out_valid, in_ready}, 32'd3);
    end
    in_valid = 1'b0;
    chk("ss_last_head", out_data, {15'd0, 17'h00100 + 17'(10 * 17'h00111)});
    chk("ss_count", 32'(ext_count), 32'(exp_count));
    tick();
    chk("ss_drained", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Asynchronous reset with two entries buffered.
    in_valid = 1'b1; in_mode = MODE_SIGN; in_data = 17'h1ABCD;
    tick();
    tick();
    in_valid = 1'b0;
    chk("ar_full", 32'(in_ready), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_ext_count", 32'(ext_count), 32'd0);
    chk("ar_in_ready",  32'(in_ready),  32'd1);
    chk("ar_out_data",  out_data,       32'd0);
    #1 reset_n = 1'b1;
    exp_count = '0;
    in_valid = 1'b1; in_mode = MODE_ZERO; in_data = 17'h00007;
    tick(); exp_count = exp_count + 16'd1;
    chk("ar_first_accept", 32'(ext_count), 32'(exp_count));
    chk("ar_first_data",   out_data,       32'h00000007);

    // Counter wrap.
    out_ready = 1'b1;
    n = 16'hFFFF - int'(exp_count);
    for (int i = 0; i < n; i++) tick();
    chk("wrap_at_ffff", 32'(ext_count), 32'h0000FFFF);
    tick();
    chk("wrap_to_zero", 32'(ext_count), 32'd0);
    in_valid = 1'b0;
    tick();
    chk("wrap_drained", 32'(out_valid), 32'd0);
    tick();
    chk("pop_empty_valid", 32'(out_valid), 32'd0);
    chk("pop_empty_count", 32'(ext_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_ext_unit

`default_nettype wire
